// File: rtl/vit_pkg.sv
// Shared definitions for the K=3, rate-1/2 Viterbi decoder frame sequencer.
package vit_pkg;

    localparam int K             = 3;
    localparam int NUM_STATES    = 4;
    localparam int FRAME_LEN_DEF = 16;

    // Path-metric width and the values loaded into the ACS array on pm_init.
    localparam int               PM_W         = 8;
    localparam logic [PM_W-1:0]  PM_INIT_ZERO = 8'd0;
    localparam logic [PM_W-1:0]  PM_INIT_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ACQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_TRACE = 3'd4,
        ST_DONE  = 3'd5
    } vit_state_t;

    // Initial path metric of trellis state st: the encoder starts in state 0.
    function automatic logic [PM_W-1:0] pm_init_value(input int unsigned st);
        return (st == 0) ? PM_INIT_ZERO : PM_INIT_MAX;
    endfunction

endpackage

// File: rtl/vit_seq_ctrl_if.sv
// Symbol stream and datapath-control bundle of the Viterbi frame sequencer.
interface vit_seq_ctrl_if
    import vit_pkg::*;
#(
    parameter int AW = $clog2(FRAME_LEN_DEF)
);
    logic          start;
    logic          busy;
    logic          sym_valid;
    logic          sym_ready;
    logic [1:0]    rx_pair;
    logic [1:0]    bmc_rx_pair;
    logic          pm_init;
    logic          acs_en;
    logic          surv_wr_en;
    logic [AW-1:0] surv_addr;
    logic          tb_first;
    logic          tb_rd_en;
    logic [AW-1:0] tb_addr;
    logic          done;

    // Demodulator / test side.
    modport master (
        output start, sym_valid, rx_pair,
        input  busy, sym_ready, bmc_rx_pair, pm_init, acs_en, surv_wr_en,
               surv_addr, tb_first, tb_rd_en, tb_addr, done
    );

    // Sequencer side.
    modport slave (
        input  start, sym_valid, rx_pair,
        output busy, sym_ready, bmc_rx_pair, pm_init, acs_en, surv_wr_en,
               surv_addr, tb_first, tb_rd_en, tb_addr, done
    );
endinterface

// File: rtl/vit_frame_cnt.sv
// Loadable up/down counter with a terminal-count compare flag.
module vit_frame_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_tc_val,
    output logic [W-1:0] o_count,
    output logic         o_tc
);
    logic [W-1:0] r_count;

    // Load has priority over counting; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? (r_count + W'(1)) : (r_count - W'(1));
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tc_val);
endmodule

// File: rtl/vit_seq_ctrl.sv
// Frame sequencer: accepts symbol pairs, drives BMC/ACS/survivor writes, then
// sweeps the survivor memory backwards for traceback and pulses done.
module vit_seq_ctrl
    import vit_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    vit_seq_ctrl_if.slave  bus
);
    localparam int AW = $clog2(FRAME_LEN);
    // One extra bit so a power-of-two frame length never wraps the index.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] TB_TOP   = AW'(FRAME_LEN - 1);

    vit_state_t    r_state;
    logic          r_busy;
    logic          r_sym_ready;
    logic [1:0]    r_bmc_rx_pair;
    logic          r_pm_init;
    logic          r_acs_en;
    logic          r_surv_wr_en;
    logic [AW-1:0] r_surv_addr;
    logic          r_tb_first;
    logic          r_tb_rd_en;
    logic          r_done;

    logic          w_accept;
    logic          w_sym_load;
    logic [CW-1:0] w_sym_cnt;
    logic          w_sym_tc;
    logic          w_tb_load;
    logic          w_tb_en;
    logic [AW-1:0] w_tb_cnt;
    logic          w_tb_tc;

    // sym_ready is only ever high in ACQ, so it doubles as the state qualifier.
    assign w_accept   = r_sym_ready & bus.sym_valid;
    assign w_sym_load = (r_state == ST_INIT);
    assign w_tb_load  = (r_state == ST_DRAIN);
    assign w_tb_en    = (r_state == ST_TRACE) & ~w_tb_tc;

    // Index of the next symbol to be accepted; tc marks the final symbol.
    vit_frame_cnt #(.W(CW)) u_sym_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_sym_load),
        .i_load_val ({CW{1'b0}}),
        .i_en       (w_accept),
        .i_up       (1'b1),
        .i_tc_val   (LAST_IDX),
        .o_count    (w_sym_cnt),
        .o_tc       (w_sym_tc)
    );

    // Traceback read address, loaded in DRAIN so it is valid on TRACE entry.
    vit_frame_cnt #(.W(AW)) u_tb_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tb_load),
        .i_load_val (TB_TOP),
        .i_en       (w_tb_en),
        .i_up       (1'b0),
        .i_tc_val   ({AW{1'b0}}),
        .o_count    (w_tb_cnt),
        .o_tc       (w_tb_tc)
    );

    // Frame FSM with all datapath strobes registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_sym_ready   <= 1'b0;
            r_bmc_rx_pair <= 2'b00;
            r_pm_init     <= 1'b0;
            r_acs_en      <= 1'b0;
            r_surv_wr_en  <= 1'b0;
            r_surv_addr   <= {AW{1'b0}};
            r_tb_first    <= 1'b0;
            r_tb_rd_en    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_pm_init    <= 1'b0;
            r_acs_en     <= 1'b0;
            r_surv_wr_en <= 1'b0;
            r_tb_first   <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_INIT;
                        r_busy    <= 1'b1;
                        r_pm_init <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_state     <= ST_ACQ;
                    r_sym_ready <= 1'b1;
                end
                ST_ACQ: begin
                    if (w_accept) begin
                        r_bmc_rx_pair <= bus.rx_pair;
                        r_acs_en      <= 1'b1;
                        r_surv_wr_en  <= 1'b1;
                        r_surv_addr   <= AW'(w_sym_cnt);
                        if (w_sym_tc) begin
                            r_state     <= ST_DRAIN;
                            r_sym_ready <= 1'b0;
                        end else begin
                            r_state <= ST_ACQ;
                        end
                    end else begin
                        r_state <= ST_ACQ;
                    end
                end
                ST_DRAIN: begin
                    r_state    <= ST_TRACE;
                    r_tb_rd_en <= 1'b1;
                    r_tb_first <= 1'b1;
                end
                ST_TRACE: begin
                    if (w_tb_tc) begin
                        r_state    <= ST_DONE;
                        r_tb_rd_en <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= ST_TRACE;
                        r_tb_rd_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_sym_ready <= 1'b0;
                    r_tb_rd_en  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.sym_ready   = r_sym_ready;
    assign bus.bmc_rx_pair = r_bmc_rx_pair;
    assign bus.pm_init     = r_pm_init;
    assign bus.acs_en      = r_acs_en;
    assign bus.surv_wr_en  = r_surv_wr_en;
    assign bus.surv_addr   = r_surv_addr;
    assign bus.tb_first    = r_tb_first;
    assign bus.tb_rd_en    = r_tb_rd_en;
    assign bus.tb_addr     = w_tb_cnt;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_vit_seq_ctrl.sv
// Scoreboard bench for vit_seq_ctrl: a FRAME_LEN=4 instance checked cycle by
// cycle against a frame-timing model, plus a FRAME_LEN=16 instance checked for
// address sequences and access counts per frame.
module tb_vit_seq_ctrl;
    localparam int F   = 4;
    localparam int AW  = $clog2(F);
    localparam int F2  = 16;
    localparam int AW2 = 4;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    vit_seq_ctrl_if #(.AW(AW))  b4 ();
    vit_seq_ctrl_if #(.AW(AW2)) b16 ();

    vit_seq_ctrl #(.FRAME_LEN(F))  dut   (.clk(clk), .rst(rst), .bus(b4));
    vit_seq_ctrl #(.FRAME_LEN(F2)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [1:0] pair; int idx; bit first; } ev_t;
    typedef struct { int cyc; bit busy; bit ready; } st_t;

    ev_t wr_q[$];
    ev_t tr_q[$];
    ev_t dn_q[$];
    ev_t pm_q[$];
    st_t st_q[$];

    int n_vec = 0;
    int n_err = 0;
    int dn16  = 0;

    // Reference model of the F=4 frame, in terms of cycle numbers.
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_acc    = 0;
    int m_end    = 0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endfunction

    // Drive one cycle of inputs and record what the model predicts.
    task automatic step(input bit st, input bit v, input logic [1:0] p, input bit r);
        int c;
        bit e_busy;
        bit e_ready;
        @(posedge clk);
        #1;
        c = cyc;
        rst = r;
        b4.start = st;     b4.sym_valid = v;  b4.rx_pair = p;
        b16.start = st;    b16.sym_valid = v; b16.rx_pair = p;
        if (r) begin
            m_active = 1'b0;
            wr_q.delete(); tr_q.delete(); dn_q.delete(); pm_q.delete(); st_q.delete();
        end else begin
            if (m_active && c > m_end) m_active = 1'b0;
            e_busy  = m_active && (c >= m_start + 1);
            e_ready = m_active && (c >= m_start + 2) && (m_acc < F);
            st_q.push_back('{c, e_busy, e_ready});
            if (e_ready && v) begin
                wr_q.push_back('{c + 1, p, m_acc, 1'b0});
                m_acc++;
                if (m_acc == F) begin
                    for (int k = 0; k < F; k++)
                        tr_q.push_back('{c + 2 + k, 2'b00, F - 1 - k, (k == 0)});
                    dn_q.push_back('{c + 2 + F, 2'b00, 0, 1'b0});
                    m_end = c + 2 + F;
                end
            end
            if (!m_active && st) begin
                m_active = 1'b1;
                m_start  = c;
                m_acc    = 0;
                m_end    = NEVER;
                pm_q.push_back('{c + 1, 2'b00, 0, 1'b0});
            end
        end
    endtask

    // Monitor: compares DUT outputs to queued expectations on every falling edge.
    initial begin : monitor
        logic [1:0] last_pair;
        int  wr16;
        int  tr16;
        st_t s;
        ev_t e;
        bit  e_acs, e_tr, e_dn, e_pm;
        last_pair = 2'b00;
        wr16 = 0;
        tr16 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", {b4.busy, b4.sym_ready, b4.bmc_rx_pair, b4.pm_init,
                    b4.acs_en, b4.surv_wr_en, b4.surv_addr, b4.tb_first, b4.tb_rd_en,
                    b4.tb_addr, b4.done}, 0);
                chk("reset_outputs16", {b16.busy, b16.sym_ready, b16.bmc_rx_pair, b16.pm_init,
                    b16.acs_en, b16.surv_wr_en, b16.surv_addr, b16.tb_first, b16.tb_rd_en,
                    b16.tb_addr, b16.done}, 0);
                last_pair = 2'b00;
                wr16 = 0;
                tr16 = 0;
            end else begin
                if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
                    s = st_q.pop_front();
                    chk("busy", b4.busy, s.busy);
                    chk("sym_ready", b4.sym_ready, s.ready);
                end else begin
                    fail("status_sync");
                end

                e_acs = (wr_q.size() != 0) && (wr_q[0].cyc == cyc);
                chk("acs_en", b4.acs_en, e_acs);
                chk("surv_wr_en", b4.surv_wr_en, e_acs);
                if (e_acs) begin
                    e = wr_q.pop_front();
                    chk("surv_addr", b4.surv_addr, e.idx);
                    last_pair = e.pair;
                end
                chk("bmc_rx_pair", b4.bmc_rx_pair, last_pair);

                e_tr = (tr_q.size() != 0) && (tr_q[0].cyc == cyc);
                chk("tb_rd_en", b4.tb_rd_en, e_tr);
                if (e_tr) begin
                    e = tr_q.pop_front();
                    chk("tb_addr", b4.tb_addr, e.idx);
                    chk("tb_first", b4.tb_first, e.first);
                end else begin
                    chk("tb_first_idle", b4.tb_first, 0);
                end

                e_dn = (dn_q.size() != 0) && (dn_q[0].cyc == cyc);
                chk("done", b4.done, e_dn);
                if (e_dn) void'(dn_q.pop_front());

                e_pm = (pm_q.size() != 0) && (pm_q[0].cyc == cyc);
                chk("pm_init", b4.pm_init, e_pm);
                if (e_pm) void'(pm_q.pop_front());

                if (b16.acs_en) begin
                    if (wr16 >= F2) fail("write16_extra");
                    chk("surv_addr16", b16.surv_addr, wr16 % F2);
                    wr16++;
                end
                if (b16.tb_rd_en) begin
                    if (tr16 >= F2) fail("read16_extra");
                    chk("tb_addr16", b16.tb_addr, (F2 - 1 - tr16) & 15);
                    chk("tb_first16", b16.tb_first, (tr16 == 0));
                    tr16++;
                end
                if (b16.done) begin
                    chk("writes16", wr16, F2);
                    chk("reads16", tr16, F2);
                    dn16++;
                    wr16 = 0;
                    tr16 = 0;
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized stretch.
    initial begin : stimulus
        logic [1:0] pat [4];
        pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b00; pat[3] = 2'b01;
        b4.start = 1'b0;  b4.sym_valid = 1'b0;  b4.rx_pair = 2'b00;
        b16.start = 1'b0; b16.sym_valid = 1'b0; b16.rx_pair = 2'b00;

        // Reset held for two cycles, then a quiet gap.
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        repeat (2) step(1'b0, 1'b0, 2'b00, 1'b0);

        // Back-to-back frame with the fixed pair pattern.
        step(1'b1, 1'b1, 2'b00, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat[i], 1'b0);
        repeat (10) step(1'b0, 1'b1, 2'($urandom), 1'b0);

        // Stalls on alternate cycles.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, i[0], 2'($urandom), 1'b0);
        repeat (10) step(1'b0, 1'b0, 2'($urandom), 1'b0);

        // start held high across a whole frame and beyond.
        repeat (30) step(1'b1, 1'b1, 2'($urandom), 1'b0);
        repeat (14) step(1'b0, 1'b1, 2'($urandom), 1'b0);

        // Ten idle cycles inside ACQ.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        repeat (10) step(1'b0, 1'b0, 2'($urandom), 1'b0);
        repeat (4) step(1'b0, 1'b1, 2'($urandom), 1'b0);
        repeat (12) step(1'b0, 1'b0, 2'($urandom), 1'b0);

        // Reset in the middle of a frame.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b0, 1'b1, 2'b10, 1'b1);
        repeat (12) step(1'b0, 1'b1, 2'($urandom), 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom % 8) == 0, ($urandom % 3) != 0, 2'($urandom),
                 ($urandom % 150) == 0);

        // Clean frame long enough for the 16-symbol instance to finish.
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 2'($urandom), 1'b0);
        repeat (40) step(1'b0, 1'b1, 2'($urandom), 1'b0);
        repeat (40) step(1'b0, 1'b0, 2'($urandom), 1'b0);

        @(negedge clk);
        #1;
        chk("wr_q_drained", wr_q.size(), 0);
        chk("tr_q_drained", tr_q.size(), 0);
        chk("dn_q_drained", dn_q.size(), 0);
        chk("pm_q_drained", pm_q.size(), 0);
        chk("frames16_seen", (dn16 >= 1), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
